// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for a multi-cycle RV32I datapath. Every instruction is
//   walked through FETCH, DECODE and the execute/memory/writeback states it
//   needs. From the current state this block drives the datapath mux selects,
//   the write enables and the 3-bit ALU operation select.
//
//   Ports
//     clk            clock, rising-edge active
//     rst            asynchronous active-high reset (state -> FETCH)
//     instr_i[31:0]  instruction register contents
//     zero_i         ALU zero flag, used for beq/bne resolution
//     pc_write_o     PC write enable
//     adr_src_o      memory address select: 0 PC, 1 ALUOut
//     mem_write_o    data memory write enable
//     ir_write_o     instruction register / old-PC write enable
//     reg_write_o    register file write enable
//     result_src_o   00 ALUOut, 01 memory data, 10 ALU result
//     alu_src_a_o    00 PC, 01 old PC, 10 rs1
//     alu_src_b_o    00 rs2, 01 immediate, 10 constant 4
//     imm_src_o      00 I, 01 S, 10 B, 11 J
//     alu_control_o  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SRL
//     illegal_o      high while trapped in ERROR
// -----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        zero_i,
    output logic        pc_write_o,
    output logic        adr_src_o,
    output logic        mem_write_o,
    output logic        ir_write_o,
    output logic        reg_write_o,
    output logic [1:0]  result_src_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  imm_src_o,
    output logic [2:0]  alu_control_o,
    output logic        illegal_o
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_ERROR
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;

    state_t state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [3:0] dec_r;   // {supported, op} for R-type
    logic [3:0] dec_i;   // {supported, op} for I-type
    logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw;
    logic       unused_instr;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign funct7b5 = instr_i[30];

    // Register numbers and immediates are consumed by the datapath, not here.
    assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    // Returns {supported, alu_op}. funct7[5] selects SUB only for R-type, so
    // addi is always ADD; the shift encodings the ALU lacks are unsupported.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       is_r);
        logic [3:0] res;
        res = {1'b0, ALU_ADD};
        case (f3)
            3'b000:  res = {1'b1, (is_r && f7b5) ? ALU_SUB : ALU_ADD};
            3'b111:  res = {1'b1, ALU_AND};
            3'b110:  res = {1'b1, ALU_OR};
            3'b100:  res = {1'b1, ALU_XOR};
            3'b010:  res = {1'b1, ALU_SLT};
            3'b101:  res = f7b5 ? {1'b0, ALU_ADD} : {1'b1, ALU_SRL};
            default: res = {1'b0, ALU_ADD};
        endcase
        return res;
    endfunction

    assign dec_r = alu_decode(funct3, funct7b5, 1'b1);
    assign dec_i = alu_decode(funct3, funct7b5, 1'b0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BR:        state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ERROR;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = dec_r[3] ? S_ALUWB : S_ERROR;
            S_EXECI:    state_d = dec_i[3] ? S_ALUWB : S_ERROR;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Moore decode; only the ALU op in EXECUTE and the branch PC write look
    // at live inputs.
    always_comb begin
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        adr_src_o     = 1'b0;
        result_src_o  = 2'b00;
        alu_src_a_o   = 2'b00;
        alu_src_b_o   = 2'b00;
        alu_control_o = ALU_ADD;
        illegal_o     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
            end
            S_DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
            end
            S_MEMREAD:  adr_src_o = 1'b1;
            S_MEMWB: begin
                result_src_o  = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_o     = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_o   = 2'b10;
                alu_control_o = dec_r[2:0];
            end
            S_EXECI: begin
                alu_src_a_o   = 2'b10;
                alu_src_b_o   = 2'b01;
                alu_control_o = dec_i[2:0];
            end
            S_ALUWB:    reg_write_raw = 1'b1;
            S_BRANCH: begin
                alu_src_a_o   = 2'b10;
                alu_control_o = ALU_SUB;
                // funct3[0] distinguishes bne (take on non-zero) from beq.
                pc_write_raw  = funct3[0] ? ~zero_i : zero_i;
            end
            S_JAL: begin
                alu_src_a_o  = 2'b01;
                alu_src_b_o  = 2'b10;
                pc_write_raw = 1'b1;
            end
            S_ERROR:    illegal_o = 1'b1;
            default:    illegal_o = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_SW:   imm_src_o = 2'b01;
            OP_BR:   imm_src_o = 2'b10;
            OP_JAL:  imm_src_o = 2'b11;
            default: imm_src_o = 2'b00;
        endcase
    end

    // The state already reads FETCH during reset; the enables are masked so
    // nothing is written until rst has been released.
    assign pc_write_o  = pc_write_raw  & ~rst;
    assign mem_write_o = mem_write_raw & ~rst;
    assign ir_write_o  = ir_write_raw  & ~rst;
    assign reg_write_o = reg_write_raw & ~rst;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Main control FSM for the multi-cycle RV32I datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath muxes and write enables.
- Drives the 3-bit ALU operation select consumed by the ALU: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SRL.
- Instructions the ALU cannot execute trap into a sticky error state.

## Interface
Parameters: none.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- instr_i  in  32  instruction register contents (valid from DECODE onward)
- zero_i  in  1  ALU zero flag
- pc_write_o  out  1  PC register write enable
- adr_src_o  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_write_o  out  1  data memory write enable
- ir_write_o  out  1  instruction register / old-PC write enable
- reg_write_o  out  1  register file write enable
- result_src_o  out  2  00 ALUOut, 01 memory data, 10 ALU result (direct)
- alu_src_a_o  out  2  00 PC, 01 old PC, 10 rs1 register
- alu_src_b_o  out  2  00 rs2 register, 01 immediate, 10 constant 4
- imm_src_o  out  2  00 I, 01 S, 10 B, 11 J
- alu_control_o  out  3  ALU operation (encoding above)
- illegal_o  out  1  high while in ERROR

## Operation
**Output style**
- All outputs are Moore-decoded from the registered state, with two exceptions:
  - alu_control_o in EXECUTER/EXECUTEI also depends on instr_i.
  - pc_write_o in BRANCH also depends on zero_i.
- Unlisted outputs are 0.
- imm_src_o is decoded from opcode in every state: lw/I-type 00, sw 01, branch 10, jal 11, others 00.

**States, outputs and transitions**
- FETCH
  - Outputs: adr_src=0, ir_write=1, src_a=00, src_b=10, ADD, result_src=10, pc_write=1.
  - Next: DECODE.
- DECODE
  - Outputs: src_a=01, src_b=01, ADD (branch/jump target into ALUOut).
  - Next by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 with funct3 000/001 → BRANCH
    - 1101111 → JAL
    - anything else → ERROR
- MEMADR
  - Outputs: src_a=10, src_b=01, ADD.
  - Next: MEMREAD if lw, MEMWRITE if sw.
- MEMREAD
  - Outputs: adr_src=1, result_src=00.
  - Next: MEMWB.
- MEMWB
  - Outputs: result_src=01, reg_write=1.
  - Next: FETCH.
- MEMWRITE
  - Outputs: adr_src=1, result_src=00, mem_write=1.
  - Next: FETCH.
- EXECUTER
  - Outputs: src_a=10, src_b=00, decoded op.
  - Next: ALUWB, or ERROR if unsupported.
- EXECUTEI
  - Outputs: src_a=10, src_b=01, decoded op.
  - Next: ALUWB, or ERROR if unsupported.
- ALUWB
  - Outputs: result_src=00, reg_write=1.
  - Next: FETCH.
- BRANCH
  - Outputs: src_a=10, src_b=00, SUB, result_src=00.
  - pc_write = zero_i for beq, ~zero_i for bne.
  - Next: FETCH.
- JAL
  - Outputs: src_a=01, src_b=10, ADD, result_src=00, pc_write=1.
  - Next: ALUWB (writes old PC + 4 to rd).
- ERROR
  - All enables 0, illegal_o=1.
  - Remains until rst.

**ALU decode (funct3, funct7[5])**
- 000: ADD.
- 000 with funct7[5]=1 in R-type only: SUB.
- 111: AND.
- 110: OR.
- 100: XOR.
- 010: SLT.
- 101 with funct7[5]=0: SRL.
- Unsupported, causing ERROR: 001 (SLL), 011 (SLTU), and 101 with funct7[5]=1 (SRA/SRAI).
- For I-type 000, funct7[5] is ignored, so addi is always ADD.

## Timing
- **Reset:** rst asserted forces the state to FETCH immediately and asynchronously.
  - While rst is high, every write enable (pc_write, ir_write, reg_write, mem_write) is forced 0.
  - Mux selects during reset take their FETCH values: src_a=00, src_b=10, alu_control=000, result_src=10, adr_src=0, illegal_o=0.
- **First fetch:** the first FETCH cycle with enables active is the first rising edge after rst deasserts.
- **Cycles per instruction:** lw 5, sw 4, R/I-type 4, beq/bne 3, jal 4, each counted from the FETCH cycle.
- **ERROR timing:** entered on the edge after the decoding state, so illegal_o rises one cycle after DECODE/EXECUTE. No write enable is asserted on the illegal instruction.
- **Branch resolution:** the branch decision uses zero_i sampled combinationally in the BRANCH cycle only.
- **Reset mid-instruction:** aborts with no further writes. A reset in MEMWRITE or MEMWB suppresses that cycle's write.

## Test plan
- **Reset:** rst=1 for 3 cycles, then release.
  - During reset, all enables must be 0.
  - The cycle after release must show FETCH outputs: ir_write=1, pc_write=1, alu_control=000.
- **R-type sub:** sub x3,x1,x2 (0x402081B3).
  - State path FETCH→DECODE→EXECUTER→ALUWB→FETCH.
  - alu_control=001 in EXECUTER; reg_write=1 only in ALUWB; 4 cycles.
- **Load and store:** lw (0x0000A183), then sw (0x0030A223).
  - lw takes 5 cycles, with adr_src=1 in MEMREAD and result_src=01 plus reg_write=1 in MEMWB.
  - sw takes 4 cycles, with mem_write=1 for exactly one cycle.
- **Branches:** beq (0x00208463) with zero_i=1, then zero_i=0; bne (0x00209463) with zero_i=1.
  - pc_write in BRANCH must be 1, 0, 0 respectively; alu_control=001; 3 cycles each.
- **Jump:** jal x1,8 (0x008000EF).
  - JAL state shows pc_write=1, src_a=01, src_b=10.
  - Then ALUWB with reg_write=1; imm_src=11 throughout.
- **Illegal and reset recovery:** sll (0x002091B3), then srai (0x4030D193).
  - Each must enter ERROR with illegal_o=1 and no write enable asserted, and must hold ERROR for 10 cycles.
  - Asserting rst returns the FSM to FETCH with illegal_o=0.
  - A separate run asserts rst during MEMWRITE: mem_write must drop to 0 immediately.
